array_reader: RTL and testbench

ARRAY_READER -- requirements
Module: array_reader

---
 rtl/array_reader.sv | 133 +++++++++++++
 tb/tb_array_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_reader.sv
// Burst reader: walks a combinational-read array from a start address and streams
// the words out through a 2-entry FIFO with valid/ready flow control.
module array_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W:0]   cmd_len,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_remaining;
   logic                r_done;
   logic [DATA_W-1:0]   r_fifo_data [2];
   logic [1:0]          r_fifo_last;
   logic                r_rd_idx;
   logic                r_wr_idx;
   logic [1:0]          r_count;

   logic                w_accept;
   logic                w_fetch;
   logic                w_pop;
   logic                w_head_last;
   logic                w_done_nxt;

   assign out_valid   = (r_count != 2'd0);
   assign w_pop       = out_valid && out_ready;
   assign w_head_last = r_fifo_last[r_rd_idx];
   assign out_data    = out_valid ? r_fifo_data[r_rd_idx] : '0;
   assign out_last    = out_valid && w_head_last;
   assign r_addr      = r_ptr;
   assign done        = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // A fetch may refill the slot freed by a same-cycle pop, giving one word per cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fetch     = 1'b0;
      w_done_nxt  = 1'b0;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               if (cmd_len != '0) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         S_FETCH: begin
            w_fetch = (r_count != 2'd2) || w_pop;
            if (w_fetch && (r_remaining == LEN_ONE)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_pop && w_head_last) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr       <= '0;
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_ptr       <= cmd_addr;
            r_remaining <= cmd_len;
         end else if (w_fetch) begin
            r_ptr       <= r_ptr + PTR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fifo_data[0] <= '0;
         r_fifo_data[1] <= '0;
         r_fifo_last    <= '0;
         r_rd_idx       <= 1'b0;
         r_wr_idx       <= 1'b0;
         r_count        <= '0;
      end else begin
         if (w_fetch) begin
            r_fifo_data[r_wr_idx] <= r_data;
            r_fifo_last[r_wr_idx] <= (r_remaining == LEN_ONE);
            r_wr_idx              <= ~r_wr_idx;
         end
         if (w_pop) r_rd_idx <= ~r_rd_idx;
         unique case ({w_fetch, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_array_reader.sv
// Bench for array_reader: directed bursts against a mem[i]=i array, with a
// scoreboard queue checked by an independent output monitor.
module tb_array_reader;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 4096;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [DEPTH];
   assign r_data = mem[r_addr];

   array_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .r_addr(r_addr), .r_data(r_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;
   exp_t sb_q[$];

   int checks = 0;
   int failures = 0;

   int done_count, busy_cycles, valid_cycles, ready_low_cycles, pops;
   int first_valid_cyc, last_cyc, done_cyc, acc_cyc;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
               failures++;
               $display("FAIL stall_hold: got valid=%0b data=%0d last=%0b, expected valid=1 data=%0d last=%0b",
                        out_valid, out_data, out_last, prev_data, prev_last);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (busy) busy_cycles++;
         if (!cmd_ready) ready_low_cycles++;
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            pops++;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL word_unexpected: got data=%0d last=%0b, expected no word", out_data, out_last);
            end else begin
               e = sb_q.pop_front();
               if (out_data !== e.data || out_last !== e.last) begin
                  failures++;
                  $display("FAIL word: got data=%0d last=%0b, expected data=%0d last=%0b",
                           out_data, out_last, e.data, e.last);
               end
            end
            if (out_last) last_cyc = cyc;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int d, input bit l);
      exp_t e;
      e.data = DW'(d);
      e.last = l;
      sb_q.push_back(e);
   endtask

   task automatic clear_mon();
      done_count       = 0;
      busy_cycles      = 0;
      valid_cycles     = 0;
      ready_low_cycles = 0;
      pops             = 0;
      first_valid_cyc  = -1;
      last_cyc         = -1;
      done_cyc         = -1;
   endtask

   task automatic issue(input int addr, input int len);
      @(posedge clk);
      #1;
      cmd_addr  = AW'(addr);
      cmd_len   = (AW+1)'(len);
      cmd_valid = 1'b1;
      @(negedge clk);
      acc_cyc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit toggle);
      logic [3:0] pat;
      bit ok;
      pat = 4'b1001;
      ok  = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_count > 0) begin
            ok = 1'b1;
            break;
         end
         #1 if (toggle) out_ready = pat[i % 4];
      end
      out_ready = 1'b1;
      chk("done_timeout", 64'(ok), 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      bit hit;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      clear_mon();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_r_addr",    64'(r_addr),    64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last",  64'(out_last),  64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_done",      64'(done),      64'd0);
      rst = 1'b1;

      // addr 10 len 4, full throughput
      clear_mon();
      push(10, 0); push(11, 0); push(12, 0); push(13, 1);
      issue(10, 4);
      wait_done(50, 1'b0);
      chk("b1_first_valid", 64'(first_valid_cyc), 64'(acc_cyc + 2));
      chk("b1_last_cycle",  64'(last_cyc),        64'(acc_cyc + 5));
      chk("b1_done_cycle",  64'(done_cyc),        64'(acc_cyc + 6));
      chk("b1_done_count",  64'(done_count),      64'd1);
      chk("b1_busy_cycles", 64'(busy_cycles),     64'd5);
      chk("b1_pops",        64'(pops),            64'd4);
      chk("b1_queue_empty", 64'(sb_q.size()),     64'd0);

      // wrap across the top of the array
      clear_mon();
      push(4094, 0); push(4095, 0); push(0, 0); push(1, 1);
      issue(4094, 4);
      wait_done(50, 1'b0);
      chk("wrap_pops",       64'(pops),        64'd4);
      chk("wrap_queue",      64'(sb_q.size()), 64'd0);
      chk("wrap_r_addr",     64'(r_addr),      64'd2);
      chk("wrap_done_count", 64'(done_count),  64'd1);

      // stalls with out_ready 1,0,0,1
      clear_mon();
      for (int k = 0; k < 8; k++) push(100 + k, k == 7);
      issue(100, 8);
      wait_done(200, 1'b1);
      chk("stall_pops",       64'(pops),        64'd8);
      chk("stall_queue",      64'(sb_q.size()), 64'd0);
      chk("stall_done_count", 64'(done_count),  64'd1);

      // zero-length command
      clear_mon();
      issue(5, 0);
      wait_done(10, 1'b0);
      chk("zero_valid_cycles", 64'(valid_cycles),     64'd0);
      chk("zero_done_count",   64'(done_count),       64'd1);
      chk("zero_done_cycle",   64'(done_cyc),         64'(acc_cyc + 1));
      chk("zero_ready_low",    64'(ready_low_cycles), 64'd0);
      chk("zero_busy",         64'(busy_cycles),      64'd0);

      // whole array
      clear_mon();
      for (int k = 0; k < DEPTH; k++) push(k, k == DEPTH - 1);
      issue(0, 4096);
      wait_done(5000, 1'b0);
      chk("full_pops",        64'(pops),            64'd4096);
      chk("full_queue",       64'(sb_q.size()),     64'd0);
      chk("full_busy_cycles", 64'(busy_cycles),     64'd4097);
      chk("full_first_valid", 64'(first_valid_cyc), 64'(acc_cyc + 2));
      chk("full_last_cycle",  64'(last_cyc),        64'(acc_cyc + 4097));
      chk("full_r_addr",      64'(r_addr),          64'd0);
      chk("full_done_count",  64'(done_count),      64'd1);

      // reset in the middle of a burst
      clear_mon();
      for (int k = 0; k < 16; k++) push(200 + k, k == 15);
      issue(200, 16);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (pops >= 3) begin
            hit = 1'b1;
            break;
         end
      end
      chk("mid_wait_timeout", 64'(hit), 64'd1);
      #1 rst = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_out_valid", 64'(out_valid), 64'd0);
      chk("mid_busy",      64'(busy),      64'd0);
      chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_done_low", 64'(done), 64'd0);
      rst = 1'b1;
      chk("mid_pops",       64'(pops),       64'd3);
      chk("mid_no_done",    64'(done_count), 64'd0);
      chk("post_cmd_ready", 64'(cmd_ready),  64'd1);
      cmd_addr  = '0;
      cmd_len   = (AW+1)'(1);
      cmd_valid = 1'b1;
      push(0, 1);
      clear_mon();
      @(negedge clk);
      acc_cyc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_done(50, 1'b0);
      chk("post_pops",         64'(pops),            64'd1);
      chk("post_queue",        64'(sb_q.size()),     64'd0);
      chk("post_first_valid",  64'(first_valid_cyc), 64'(acc_cyc + 2));
      chk("post_done_count",   64'(done_count),      64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
